ibus_responder: RTL and testbench

//   Responder end of the instruction bus: accepts ibus_req_t from the fetch stage, holds it for a

---
 rtl/ibus_responder_pkg.sv | 32 +++
 rtl/ibus_responder_if.sv | 19 +
 rtl/ibus_responder_imem_ram.sv | 27 ++
 rtl/ibus_responder.sv | 118 +++++++++++
 tb/tb_ibus_responder.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/ibus_responder_pkg.sv
// Shared types for the instruction-bus responder.
// Request/response bundles, base address default, FSM states, fault helper.
package ibus_responder_pkg;

  localparam logic [63:0] IBUS_BASE_ADDR = 64'h8000_0000;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } ibus_state_t;

  // A request faults when misaligned or outside [base, lim).
  function automatic logic ibus_addr_fault(
    input logic [63:0] a,
    input logic [63:0] base,
    input logic [63:0] lim
  );
    return (a[1:0] != 2'b00) || (a < base) || (a >= lim);
  endfunction

endpackage

// File: rtl/ibus_responder_if.sv
// Fetch <-> responder instruction bus bundle.
// master = fetch side (drives ireq), slave = responder (drives iresp).
interface ibus_responder_if;
  import ibus_responder_pkg::*;

  ibus_req_t  ireq;
  ibus_resp_t iresp;

  modport master (
    output ireq,
    input  iresp
  );

  modport slave (
    input  ireq,
    output iresp
  );

endinterface

// File: rtl/ibus_responder_imem_ram.sv
// Word-addressed instruction RAM: one sync write port, one async read port.
// Ports: clk, we_i/waddr_i/wdata_i (write), raddr_i -> rdata_o (read).
module imem_ram #(
  parameter int unsigned DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] waddr_i,
  input  logic [31:0]           wdata_i,
  input  logic [DEPTH_LOG2-1:0] raddr_i,
  output logic [31:0]           rdata_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [31:0] mem_q [DEPTH];

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ibus_responder.sv
// Instruction-bus responder: accepts fetch requests, answers after LATENCY
// cycles with one data_ok pulse. Ports: clk, reset, ibus (slave),
// ld_en/ld_idx/ld_data (backdoor preload), fault (bad address on data_ok).
module ibus_responder
  import ibus_responder_pkg::*;
#(
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter logic [63:0] BASE_ADDR  = IBUS_BASE_ADDR
) (
  input  logic                  clk,
  input  logic                  reset,
  ibus_responder_if.slave       ibus,
  input  logic                  ld_en,
  input  logic [DEPTH_LOG2-1:0] ld_idx,
  input  logic [31:0]           ld_data,
  output logic                  fault
);

  localparam logic [63:0] SPAN     = 64'd4 << DEPTH_LOG2;
  localparam logic [63:0] END_ADDR = BASE_ADDR + SPAN;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  ibus_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] addr_q, addr_d;

  ibus_req_t   req;
  logic        addr_ok;
  logic        data_ok;
  logic        bad;
  logic [63:0] off;
  logic [31:0] rdata;
  logic        ram_we;
  logic        unused_off;

  assign req = ibus.ireq;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    addr_ok = 1'b0;
    data_ok = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req.valid) begin
          addr_ok = 1'b1;
          addr_d  = req.addr;
          cnt_d   = CNT_INIT;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!req.valid) begin
          state_d = IDLE;
        end else if (req.addr != addr_q) begin
          // Redirect: restart full latency from the new address.
          addr_ok = 1'b1;
          addr_d  = req.addr;
          cnt_d   = CNT_INIT;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          data_ok = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Word index relative to BASE_ADDR; high and byte bits only matter for fault.
  assign off        = addr_q - BASE_ADDR;
  assign unused_off = ^{off[63:DEPTH_LOG2+2], off[1:0]};
  assign bad        = ibus_addr_fault(addr_q, BASE_ADDR, END_ADDR);

  // Preload only when idle and no request competes for the cycle.
  assign ram_we = ld_en && !reset && (state_q == IDLE) && !req.valid;

  imem_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (ld_idx),
    .wdata_i (ld_data),
    .raddr_i (off[DEPTH_LOG2+1:2]),
    .rdata_o (rdata)
  );

  // Outputs are forced quiet while reset is held, even if fetch keeps valid.
  always_comb begin
    ibus.iresp = '0;
    fault      = 1'b0;
    if (!reset) begin
      ibus.iresp.addr_ok = addr_ok;
      ibus.iresp.data_ok = data_ok;
      fault              = data_ok && bad;
      if (data_ok && !bad) begin
        ibus.iresp.data = rdata;
      end
    end
  end

endmodule

// File: tb/tb_ibus_responder.sv
// Directed bench for ibus_responder (LATENCY=2, 4096 words at 0x8000_0000).
// Table-driven cycle vectors plus a hand sequence for async reset mid-request.
module tb_ibus_responder;
  import ibus_responder_pkg::*;

  typedef struct {
    logic        valid;
    logic [63:0] addr;
    logic        aok;
    logic        dok;
    logic [31:0] data;
    logic        flt;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ld_en = 1'b0;
  logic [11:0] ld_idx = '0;
  logic [31:0] ld_data = '0;
  logic        fault;

  int n_vec = 0;
  int n_err = 0;

  vec_t tbl[$];

  ibus_responder_if ibus ();

  ibus_responder #(
    .LATENCY    (2),
    .DEPTH_LOG2 (12),
    .BASE_ADDR  (64'h8000_0000)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .ibus    (ibus.slave),
    .ld_en   (ld_en),
    .ld_idx  (ld_idx),
    .ld_data (ld_data),
    .fault   (fault)
  );

  always #5 clk = ~clk;

  task automatic add(input logic v, input logic [63:0] a,
                     input logic aok, input logic dok,
                     input logic [31:0] d, input logic f);
    vec_t e;
    e.valid = v; e.addr = a; e.aok = aok;
    e.dok = dok; e.data = d; e.flt = f;
    tbl.push_back(e);
  endtask

  task automatic check(input string nm, input logic aok,
                       input logic dok, input logic [31:0] d,
                       input logic f);
    n_vec++;
    if (ibus.iresp.addr_ok !== aok || ibus.iresp.data_ok !== dok ||
        ibus.iresp.data !== d || fault !== f) begin
      n_err++;
      $display("FAIL %s: got aok=%b dok=%b data=%h fault=%b want aok=%b dok=%b data=%h fault=%b",
               nm, ibus.iresp.addr_ok, ibus.iresp.data_ok,
               ibus.iresp.data, fault, aok, dok, d, f);
    end
  endtask

  task automatic preload(input logic [11:0] i, input logic [31:0] d);
    @(negedge clk);
    ibus.ireq.valid = 1'b0;
    ld_en = 1'b1; ld_idx = i; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic drive(input logic v, input logic [63:0] a);
    @(negedge clk);
    ibus.ireq.valid = v;
    ibus.ireq.addr  = a;
    #2;
  endtask

  // Fault request pattern: accept, wait, data_ok with fault, idle.
  task automatic add_fault(input logic [63:0] a);
    add(1, a, 1, 0, 32'h0, 0);
    add(1, a, 0, 0, 32'h0, 0);
    add(1, a, 0, 1, 32'h0, 1);
    add(0, 0, 0, 0, 32'h0, 0);
  endtask

  initial begin
    ibus.ireq.valid = 1'b1;
    ibus.ireq.addr  = 64'h8000_0000;
    #2;
    check("reset_quiet", 0, 0, 32'h0, 0);
    @(negedge clk);
    ibus.ireq.valid = 1'b0;
    reset = 1'b0;

    preload(12'd0,    32'h0000_0013);
    preload(12'd1,    32'h0010_0093);
    preload(12'd2,    32'hDEAD_BEEF);
    preload(12'd4095, 32'hCAFE_F00D);

    // Single request, LATENCY=2.
    add(1, 64'h8000_0000, 1, 0, 32'h0, 0);
    add(1, 64'h8000_0000, 0, 0, 32'h0, 0);
    add(1, 64'h8000_0000, 0, 1, 32'h0000_0013, 0);
    add(0, 64'h0,         0, 0, 32'h0, 0);
    // Held valid, back-to-back.
    add(1, 64'h8000_0000, 1, 0, 32'h0, 0);
    add(1, 64'h8000_0000, 0, 0, 32'h0, 0);
    add(1, 64'h8000_0000, 0, 1, 32'h0000_0013, 0);
    add(1, 64'h8000_0004, 1, 0, 32'h0, 0);
    add(1, 64'h8000_0004, 0, 0, 32'h0, 0);
    add(1, 64'h8000_0004, 0, 1, 32'h0010_0093, 0);
    add(0, 64'h0,         0, 0, 32'h0, 0);
    // Redirect one cycle after acceptance.
    add(1, 64'h8000_0000, 1, 0, 32'h0, 0);
    add(1, 64'h8000_0008, 1, 0, 32'h0, 0);
    add(1, 64'h8000_0008, 0, 0, 32'h0, 0);
    add(1, 64'h8000_0008, 0, 1, 32'hDEAD_BEEF, 0);
    add(0, 64'h0,         0, 0, 32'h0, 0);
    // Cancel, then a fresh request is accepted at T+2.
    add(1, 64'h8000_0004, 1, 0, 32'h0, 0);
    add(0, 64'h8000_0004, 0, 0, 32'h0, 0);
    add(1, 64'h8000_0008, 1, 0, 32'h0, 0);
    add(1, 64'h8000_0008, 0, 0, 32'h0, 0);
    add(1, 64'h8000_0008, 0, 1, 32'hDEAD_BEEF, 0);
    add(0, 64'h0,         0, 0, 32'h0, 0);
    // Last legal word, then faults.
    add(1, 64'h8000_3FFC, 1, 0, 32'h0, 0);
    add(1, 64'h8000_3FFC, 0, 0, 32'h0, 0);
    add(1, 64'h8000_3FFC, 0, 1, 32'hCAFE_F00D, 0);
    add(0, 64'h0,         0, 0, 32'h0, 0);
    add_fault(64'h8000_0002);
    add_fault(64'h7FFF_FFFC);
    add_fault(64'h8000_4000);
    add_fault(64'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].valid, tbl[i].addr);
      check($sformatf("vec%0d", i), tbl[i].aok, tbl[i].dok,
            tbl[i].data, tbl[i].flt);
    end

    // Async reset mid-BUSY; ld_en while requesting/busy must be ignored.
    @(negedge clk);
    ibus.ireq.valid = 1'b1;
    ibus.ireq.addr  = 64'h8000_0000;
    ld_en = 1'b1; ld_idx = 12'd0; ld_data = 32'hFFFF_FFFF;
    #2;
    check("rst_accept", 1, 0, 32'h0, 0);
    @(negedge clk);
    #1;
    check("rst_busy", 0, 0, 32'h0, 0);
    reset = 1'b1;
    #1;
    check("rst_async", 0, 0, 32'h0, 0);
    ld_en = 1'b0;
    @(negedge clk);
    #2;
    check("rst_held", 0, 0, 32'h0, 0);
    @(negedge clk);
    reset = 1'b0;
    #2;
    check("rst_idle_accept", 1, 0, 32'h0, 0);
    drive(1, 64'h8000_0000);
    check("rst_wait", 0, 0, 32'h0, 0);
    drive(1, 64'h8000_0000);
    check("rst_readback", 0, 1, 32'h0000_0013, 0);
    drive(0, 64'h0);
    check("rst_end_idle", 0, 0, 32'h0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
